// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master: one cmd in, one rsp out; AW and W issued together, retired independently.
// All AXI handshake outputs and rsp_* are registered; cmd_ready is high only in IDLE, rsp held until rsp_ready.
module axi_lite_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    WVALID,
  input  logic                    WREADY,
  input  logic [1:0]              BRESP,
  input  logic                    BVALID,
  output logic                    BREADY,
  output logic [ADDR_WIDTH-1:0]   ARADDR,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  input  logic [DATA_WIDTH-1:0]   RDATA,
  input  logic [1:0]              RRESP,
  input  logic                    RVALID,
  output logic                    RREADY
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   awaddr_nxt, araddr_nxt;
  logic [DATA_WIDTH-1:0]   wdata_nxt, rsp_rdata_nxt;
  logic                    awvalid_nxt, wvalid_nxt, bready_nxt, arvalid_nxt, rready_nxt;
  logic                    rsp_valid_nxt, rsp_write_nxt;
  logic [1:0]              rsp_resp_nxt;

  assign cmd_ready = (state == IDLE);
  assign WSTRB     = '1;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state     <= IDLE;
      AWADDR    <= '0;
      AWVALID   <= 1'b0;
      WDATA     <= '0;
      WVALID    <= 1'b0;
      BREADY    <= 1'b0;
      ARADDR    <= '0;
      ARVALID   <= 1'b0;
      RREADY    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= 2'b00;
    end else begin
      state     <= state_nxt;
      AWADDR    <= awaddr_nxt;
      AWVALID   <= awvalid_nxt;
      WDATA     <= wdata_nxt;
      WVALID    <= wvalid_nxt;
      BREADY    <= bready_nxt;
      ARADDR    <= araddr_nxt;
      ARVALID   <= arvalid_nxt;
      RREADY    <= rready_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_write <= rsp_write_nxt;
      rsp_rdata <= rsp_rdata_nxt;
      rsp_resp  <= rsp_resp_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    awaddr_nxt    = AWADDR;
    awvalid_nxt   = AWVALID;
    wdata_nxt     = WDATA;
    wvalid_nxt    = WVALID;
    bready_nxt    = BREADY;
    araddr_nxt    = ARADDR;
    arvalid_nxt   = ARVALID;
    rready_nxt    = RREADY;
    rsp_valid_nxt = rsp_valid;
    rsp_write_nxt = rsp_write;
    rsp_rdata_nxt = rsp_rdata;
    rsp_resp_nxt  = rsp_resp;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_write) begin
            awaddr_nxt  = cmd_addr;
            wdata_nxt   = cmd_wdata;
            awvalid_nxt = 1'b1;
            wvalid_nxt  = 1'b1;
            state_nxt   = WR_REQ;
          end else begin
            araddr_nxt  = cmd_addr;
            arvalid_nxt = 1'b1;
            state_nxt   = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        if (AWVALID && AWREADY) awvalid_nxt = 1'b0;
        if (WVALID && WREADY)   wvalid_nxt  = 1'b0;
        // Both channels retired (possibly the last one this very cycle).
        if (!awvalid_nxt && !wvalid_nxt) begin
          bready_nxt = 1'b1;
          state_nxt  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (BVALID && BREADY) begin
          bready_nxt    = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_write_nxt = 1'b1;
          rsp_rdata_nxt = '0;
          rsp_resp_nxt  = BRESP;
          state_nxt     = RSP;
        end
      end
      RD_REQ: begin
        if (ARVALID && ARREADY) begin
          arvalid_nxt = 1'b0;
          rready_nxt  = 1'b1;
          state_nxt   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (RVALID && RREADY) begin
          rready_nxt    = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_write_nxt = 1'b0;
          rsp_rdata_nxt = RDATA;
          rsp_resp_nxt  = RRESP;
          state_nxt     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
- Upstream AXI4-Lite master that bridges a simple single-beat command/response interface onto the AXI4-Lite read and write channels.
- It drives the register-bank slave in the same design.
- Exactly one transaction is outstanding at a time.
- The write address (AW) and write data (W) channels are issued concurrently and are retired independently.

Parameters:
- ADDR_WIDTH, 32, width of the command address and of AWADDR/ARADDR
- DATA_WIDTH, 32, width of the command write data, response read data, WDATA and RDATA

Ports:
- ACLK  input  1  clock; all logic on the rising edge
- ARESET  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  master can accept a command
- cmd_write  input  1  1 = write, 0 = read
- cmd_addr  input  ADDR_WIDTH  target byte address
- cmd_wdata  input  DATA_WIDTH  write data (ignored for reads)
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts the response
- rsp_write  output  1  response belongs to a write
- rsp_rdata  output  DATA_WIDTH  read data (0 for writes)
- rsp_resp  output  2  captured BRESP or RRESP
- AWADDR  output  ADDR_WIDTH
- AWVALID  output  1
- AWREADY  input  1
- WDATA  output  DATA_WIDTH
- WSTRB  output  DATA_WIDTH/8  tied all-ones
- WVALID  output  1
- WREADY  input  1
- BRESP  input  2
- BVALID  input  1
- BREADY  output  1
- ARADDR  output  ADDR_WIDTH
- ARVALID  output  1
- ARREADY  input  1
- RDATA  input  DATA_WIDTH
- RRESP  input  2
- RVALID  input  1
- RREADY  output  1

Behaviour:
- Reset:
  - ARESET high, asynchronous: state = IDLE.
  - All VALID/READY outputs = 0 (AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid).
  - Address, data and response registers = 0.
  - Reset mid-transaction abandons it: no response is produced.
- State machine states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- cmd_ready:
  - cmd_ready = 1 only in IDLE (combinational from state).
  - A command is accepted on a cycle with cmd_valid && cmd_ready.
- IDLE -> WR_REQ on an accepted write:
  - Register AWADDR = cmd_addr and WDATA = cmd_wdata.
  - AWVALID = 1 and WVALID = 1 from the next cycle.
- WR_REQ:
  - AWVALID drops the cycle after its own AWVALID && AWREADY.
  - WVALID drops the cycle after its own WVALID && WREADY.
  - The two may complete in either order or in the same cycle.
  - VALID is never withdrawn before its READY has been seen.
  - When both have completed (including a same-cycle completion of the last one) -> WR_RESP with BREADY = 1.
- WR_RESP:
  - On BVALID && BREADY: capture BRESP into rsp_resp, rsp_rdata = 0, rsp_write = 1.
  - BREADY drops; -> RSP.
- IDLE -> RD_REQ on an accepted read:
  - ARADDR = cmd_addr, ARVALID = 1.
- RD_REQ:
  - On ARVALID && ARREADY: ARVALID drops, RREADY = 1, -> RD_DATA.
- RD_DATA:
  - On RVALID && RREADY: capture RDATA into rsp_rdata and RRESP into rsp_resp, rsp_write = 0.
  - RREADY drops; -> RSP.
- RSP:
  - rsp_valid = 1; outputs held stable until rsp_ready.
  - On rsp_valid && rsp_ready -> IDLE; rsp_valid = 0 next cycle.
- Output registration: all AXI VALID/READY outputs and all rsp_* outputs are registered; no combinational path from any AXI input to any AXI output.
- Latency:
  - Against a slave with READY always high, a read takes command accept -> ARVALID 1 cycle, then AR handshake, then RDATA.
  - rsp_valid rises the cycle after the R handshake.
  - A new command can be accepted the cycle after the rsp handshake; there are no back-to-back commands without passing through IDLE.
- rsp_resp is passed through unmodified: SLVERR/DECERR are reported to the consumer, not retried.
- B or R beats arriving in states other than WR_RESP/RD_DATA are ignored; BREADY/RREADY are 0 there.
- Address and data are driven as given, with no alignment checking.

Test Plan:
- Write with slave READYs always 1: cmd write addr 0x4, data 0xDEADBEEF.
  -> AWVALID and WVALID high together for 1 cycle, then B handshake.
  -> rsp_valid with rsp_write=1, rsp_resp=00.
- Read back: cmd read addr 0x4 -> AR handshake, then R handshake -> rsp_rdata=0xDEADBEEF, rsp_write=0, rsp_resp=00.
- Skewed write handshakes: AWREADY at cycle 2, WREADY at cycle 5.
  -> AWVALID low from cycle 3, WVALID held until 5.
  -> BREADY asserted only after cycle 5.
  -> Then W-first ordering (WREADY 1, AWREADY 4) gives the same result.
- Error and backpressure: slave returns RRESP=10 and rsp_ready is held 0 for 4 cycles.
  -> rsp_resp=10, rsp_valid and rsp_rdata stable for all 4 cycles.
  -> cmd_ready stays 0 until the rsp handshake.
- Reset during WR_RESP (ARESET pulsed while BVALID=0):
  -> all VALID/READY outputs 0 asynchronously, no rsp_valid.
  -> cmd_ready=1 after release.
- Four alternating write/read commands to addresses 0x0, 0x4, 0x8, 0xC with cmd_valid held high.
  -> Exactly one AXI transaction at a time, responses in order, read data equals prior writes.
